// File: rtl/addsub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int OP_SUB     = 0;
  localparam int OP_USE_CIN = 1;

  // Operand width must split into whole digits.
  function automatic bit geometry_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-wide ripple of full adders; B is conditionally inverted for subtract.
module addsub_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             sub,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] bx;

  assign c[0] = ci;
  assign bx   = b ^ {DIGIT{sub}};

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = a[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end

  assign co    = c[DIGIT];
  assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial adder/subtractor: NDIG RUN cycles per operation, results and
// flags registered together on completion, start/done handshake.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             Busy,
  output logic             Done
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  if (!geometry_ok(WIDTH, DIGIT)) begin : g_bad_geometry
    $error("addsub_seq: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t state, state_next;
  logic             accept;
  logic             last;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, res, res_next;
  logic             sub_r;
  logic             carry;
  logic [DIGIT-1:0] dig_s;
  logic             dig_co, dig_cmsb;

  assign last = (cnt == LAST_CNT);

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_r[DIGIT-1:0]),
    .b     (b_r[DIGIT-1:0]),
    .sub   (sub_r),
    .ci    (carry),
    .s     (dig_s),
    .co    (dig_co),
    .c_msb (dig_cmsb)
  );

  // Result slices enter at the top and shift down, so after NDIG cycles
  // digit 0 sits at the LSB.
  if (NDIG == 1) begin : g_one_digit
    assign res_next = dig_s;
  end else begin : g_multi_digit
    assign res_next = {dig_s, res[WIDTH-1:DIGIT]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN:  if (last) state_next = DONE;
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      res   <= '0;
      sub_r <= 1'b0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
      Zero  <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Busy <= (state_next == RUN);
      Done <= (state == RUN) && last;
      if (accept) begin
        a_r   <= A;
        b_r   <= B;
        sub_r <= Op[OP_SUB];
        carry <= Op[OP_SUB] ^ (Op[OP_USE_CIN] & Cin);
        cnt   <= '0;
        res   <= '0;
      end else if (state == RUN) begin
        a_r   <= a_r >> DIGIT;
        b_r   <= b_r >> DIGIT;
        carry <= dig_co;
        res   <= res_next;
        if (!last) cnt <= cnt + 1'b1;
        if (last) begin
          Sum  <= res_next;
          Cout <= dig_co ^ sub_r;
          Ovf  <= dig_cmsb ^ dig_co;
          Zero <= (res_next == '0);
        end
      end
    end
  end

endmodule
